// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC, issues one IMEM read per cycle and buffers responses
// in a 2-entry queue presented to decode through a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        exc_valid,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_adel
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        adel;
  } entry_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        infl_q, infl_d;
  logic [31:0] tag_pc_q, tag_pc_d;
  logic        tag_adel_q, tag_adel_d;
  logic [1:0]  occ_q, occ_d;
  entry_t      q0_q, q0_d, q1_q, q1_d;

  logic        flush, pop, push, go;
  logic [2:0]  used;
  entry_t      new_entry;

  assign flush = exc_valid | redir_valid;
  assign pop   = inst_valid & inst_ready;
  assign push  = infl_q & ~flush;
  // Credits: queued entries plus the in-flight fetch, minus the one leaving now.
  assign used  = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
  assign go    = ~reset & ~flush & (state_q == S_RUN) & (used < 3'd2);

  assign new_entry.data = tag_adel_q ? '0 : imem_rdata;
  assign new_entry.pc   = tag_pc_q;
  assign new_entry.adel = tag_adel_q;

  assign imem_addr  = pc_q;
  assign inst_valid = (occ_q != 2'd0);
  assign inst       = q0_q.data;
  assign inst_pc    = q0_q.pc;
  assign inst_adel  = q0_q.adel;

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    infl_d     = go;
    tag_pc_d   = tag_pc_q;
    tag_adel_d = tag_adel_q;
    imem_req   = 1'b0;
    if (flush) begin
      pc_d    = exc_valid ? EXC_PC : redir_pc;
      state_d = S_RUN;
    end else if (go) begin
      tag_pc_d = pc_q;
      if (pc_q[1:0] == 2'b00) begin
        imem_req   = 1'b1;
        pc_d       = pc_q + 32'd4;
        tag_adel_d = 1'b0;
      end else begin
        tag_adel_d = 1'b1;
        state_d    = S_HALT;
      end
    end
  end

  // Slot 1 is kept zero whenever occ<2 and slot 0 whenever empty, so the
  // head outputs read as zero while nothing is queued.
  always_comb begin
    occ_d = occ_q;
    q0_d  = q0_q;
    q1_d  = q1_q;
    if (flush) begin
      occ_d = 2'd0;
      q0_d  = '0;
      q1_d  = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) q0_d = new_entry;
          else               q1_d = new_entry;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          q0_d  = q1_q;
          q1_d  = '0;
          occ_d = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            q0_d = new_entry;
          end else begin
            q0_d = q1_q;
            q1_d = new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      infl_q     <= 1'b0;
      tag_pc_q   <= '0;
      tag_adel_q <= 1'b0;
      occ_q      <= 2'd0;
      q0_q       <= '0;
      q1_q       <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      infl_q     <= infl_d;
      tag_pc_q   <= tag_pc_d;
      tag_adel_q <= tag_adel_d;
      occ_q      <= occ_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: IMEM returns its own address, expected
// deliveries are queued at each (re)start and compared on every pop.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        exc_valid = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_adel;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   pop_cnt = 0;

  fetch_unit #(.RESET_PC(32'h0000_3000), .EXC_PC(32'h0000_4180)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .exc_valid(exc_valid), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_adel(inst_adel)
  );

  always #5 clk = ~clk;

  // IMEM[a] = a, one-cycle read latency
  always @(posedge clk) imem_rdata <= imem_req ? imem_addr : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    a = start;
    if (start[1:0] != 2'b00) begin
      exp_q.push_back('{pc: start, data: 32'h0, adel: 1'b1});
    end else begin
      for (int unsigned i = 0; i < 40; i++) begin
        exp_q.push_back('{pc: a, data: a, adel: 1'b0});
        a = a + 32'd4;
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_adel", {31'b0, inst_adel}, 32'h0);
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
  endtask

  // Called at posedge+1; redirect occupies cycle T, target visible in T+3.
  task automatic do_redir(input logic exc, input logic [31:0] tgt_pc, input logic [31:0] expect_pc);
    redir_valid = 1'b1;
    exc_valid   = exc;
    redir_pc    = tgt_pc;
    #1;
    check("redir_no_req", {31'b0, imem_req}, 32'h0);
    step(1);
    redir_valid = 1'b0;
    exc_valid   = 1'b0;
    push_stream(expect_pc);
    #1;
    check("tgt_req", {31'b0, imem_req}, {31'b0, (expect_pc[1:0] == 2'b00)});
    check("tgt_addr", imem_addr, expect_pc);
    check("tgt_valid_t1", {31'b0, inst_valid}, 32'h0);
    step(1);
    check("tgt_valid_t2", {31'b0, inst_valid}, 32'h0);
    step(1);
    check("tgt_valid_t3", {31'b0, inst_valid}, 32'h1);
    check("tgt_pc_t3", inst_pc, expect_pc);
  endtask

  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst", inst, e.data);
        check("inst_adel", {31'b0, inst_adel}, {31'b0, e.adel});
      end
    end
  end

  initial begin
    int p0;
    int reqs;
    #2 reset = 1'b1;
    step(3);
    #1;
    check_reset_outputs();

    // reset release: req in cycle 0, inst_valid in cycle 2, then back to back
    @(posedge clk); #1;
    push_stream(32'h0000_3000);
    reset = 1'b0;
    #1;
    check("c0_req", {31'b0, imem_req}, 32'h1);
    check("c0_addr", imem_addr, 32'h0000_3000);
    check("c0_valid", {31'b0, inst_valid}, 32'h0);
    step(1);
    check("c1_valid", {31'b0, inst_valid}, 32'h0);
    step(1);
    check("c2_valid", {31'b0, inst_valid}, 32'h1);
    check("c2_pc", inst_pc, 32'h0000_3000);
    p0 = pop_cnt;
    step(6);
    check("stream_pops", pop_cnt - p0, 32'd6);

    // backpressure from an empty queue: two issues fill the queue, then stall
    inst_ready = 1'b0;
    redir_valid = 1'b1;
    redir_pc = 32'h0000_3000;
    step(1);
    redir_valid = 1'b0;
    push_stream(32'h0000_3000);
    reqs = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      #1;
      if (imem_req) reqs++;
      step(1);
    end
    check("stall_issues", reqs, 32'd2);
    check("stall_req_low", {31'b0, imem_req}, 32'h0);
    check("stall_valid", {31'b0, inst_valid}, 32'h1);
    check("stall_head", inst_pc, 32'h0000_3000);
    inst_ready = 1'b1;
    p0 = pop_cnt;
    step(6);
    check("release_pops", pop_cnt - p0, 32'd6);

    // redirect with an entry queued and a fetch in flight
    check("pre_redir_valid", {31'b0, inst_valid}, 32'h1);
    do_redir(1'b0, 32'h0000_3100, 32'h0000_3100);
    step(4);

    // exception wins over a simultaneous redirect
    do_redir(1'b1, 32'h0000_3200, 32'h0000_4180);
    step(4);

    // misaligned target: one adel marker, then halted
    do_redir(1'b0, 32'h0000_3102, 32'h0000_3102);
    check("adel_inst", inst, 32'h0);
    check("adel_flag", {31'b0, inst_adel}, 32'h1);
    reqs = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (imem_req) reqs++;
      step(1);
    end
    check("halt_no_req", reqs, 32'd0);
    check("halt_empty", {31'b0, inst_valid}, 32'h0);
    do_redir(1'b0, 32'h0000_3000, 32'h0000_3000);
    step(3);

    // PC wrap
    do_redir(1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    step(4);

    // asynchronous reset mid-stream
    #2 reset = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    step(2);
    push_stream(32'h0000_3000);
    reset = 1'b0;
    #1;
    check("rr_req", {31'b0, imem_req}, 32'h1);
    check("rr_addr", imem_addr, 32'h0000_3000);
    step(2);
    check("rr_valid", {31'b0, inst_valid}, 32'h1);
    check("rr_pc", inst_pc, 32'h0000_3000);
    step(3);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
